// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared encodings for the inst/data SRAM port arbiter
package sram_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam int DEFAULT_OUTSTANDING = 2;

    typedef enum logic {
        LK_IDLE = 1'b0,
        LK_LOCK = 1'b1
    } lock_state_t;

endpackage

// File: rtl/arb_id_fifo.sv
// rtl/arb_id_fifo.sv - in-order source-ID FIFO for outstanding shared-port transactions
module arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] slots;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = slots[rd_ptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                slots[wr_ptr] <= din;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one SRAM-like port between fetch and memory stages, data first
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = DEFAULT_OUTSTANDING,
    parameter int ID_W        = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(OUTSTANDING) + ID_W;

    lock_state_t state, state_nxt;
    logic        locked_id, locked_id_nxt;
    logic        grant;
    logic        grant_req;
    logic        fire;
    logic        pop;
    logic        fifo_head;
    logic        fifo_full;
    logic        fifo_empty;

    // A pending-but-unaccepted request pins the grant so the port request stays stable
    assign grant     = (state == LK_LOCK) ? locked_id
                     : (data_sram_req ? SRC_DATA : SRC_INST);
    assign grant_req = (grant == SRC_DATA) ? data_sram_req : inst_sram_req;
    assign mem_req   = ~reset & grant_req & ~fifo_full;
    assign fire      = mem_req & mem_addr_ok;
    assign pop       = ~reset & mem_data_ok & ~fifo_empty;

    arb_id_fifo #(
        .DEPTH (OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (fire),
        .din   (grant),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LK_IDLE;
            locked_id <= SRC_INST;
        end else begin
            state     <= state_nxt;
            locked_id <= locked_id_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        locked_id_nxt = locked_id;
        case (state)
            LK_IDLE: begin
                if (mem_req && !mem_addr_ok) begin
                    state_nxt     = LK_LOCK;
                    locked_id_nxt = grant;
                end
            end
            LK_LOCK: begin
                if (fire) begin
                    state_nxt = LK_IDLE;
                end
            end
            default: state_nxt = LK_IDLE;
        endcase
    end

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = 32'd0;
        mem_wstrb = 4'd0;
        mem_wdata = 32'd0;
        if (!reset) begin
            if (grant == SRC_DATA) begin
                mem_wr    = data_sram_wr;
                mem_size  = data_sram_size;
                mem_addr  = data_sram_addr;
                mem_wstrb = data_sram_wstrb;
                mem_wdata = data_sram_wdata;
            end else begin
                mem_wr    = inst_sram_wr;
                mem_size  = inst_sram_size;
                mem_addr  = inst_sram_addr;
                mem_wstrb = inst_sram_wstrb;
                mem_wdata = inst_sram_wdata;
            end
        end
    end

    assign inst_sram_addr_ok = fire & (grant == SRC_INST);
    assign data_sram_addr_ok = fire & (grant == SRC_DATA);

    assign inst_sram_data_ok = pop & (fifo_head == SRC_INST);
    assign data_sram_data_ok = pop & (fifo_head == SRC_DATA);
    assign inst_sram_rdata   = inst_sram_data_ok ? mem_rdata : 32'd0;
    assign data_sram_rdata   = data_sram_data_ok ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic [3:0]  inst_sram_wstrb;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [3:0]  data_sram_wstrb;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        src;
        logic [31:0] rdata;
        bit          chk_rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    sram_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mem_req           (mem_req),
        .mem_wr            (mem_wr),
        .mem_size          (mem_size),
        .mem_addr          (mem_addr),
        .mem_wstrb         (mem_wstrb),
        .mem_wdata         (mem_wdata),
        .mem_addr_ok       (mem_addr_ok),
        .mem_data_ok       (mem_data_ok),
        .mem_rdata         (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_sram_req = 1'b0;
        data_sram_req = 1'b0;
        inst_sram_wr  = 1'b0;
        data_sram_wr  = 1'b0;
        mem_addr_ok   = 1'b0;
        mem_data_ok   = 1'b0;
        mem_rdata     = 32'd0;
    endtask

    task automatic respond(input logic src, input logic [31:0] rdata, input bit chk_rd);
        mem_data_ok = 1'b1;
        mem_rdata   = rdata;
        exp_q.push_back('{src: src, rdata: rdata, chk_rdata: chk_rd});
    endtask

    // Monitor: every data_ok pulse consumes the oldest expected response
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] rd;
        logic [31:0] other;
        if (!reset && (inst_sram_data_ok || data_sram_data_ok)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_data_ok: inst=%0b data=%0b expected no response",
                         inst_sram_data_ok, data_sram_data_ok);
            end else begin
                e = exp_q.pop_front();
                chk("resp_one_hot", 32'(inst_sram_data_ok & data_sram_data_ok), 32'd0);
                chk("resp_src", 32'(data_sram_data_ok), 32'(e.src));
                rd    = e.src ? data_sram_rdata : inst_sram_rdata;
                other = e.src ? inst_sram_rdata : data_sram_rdata;
                if (e.chk_rdata) chk("resp_rdata", rd, e.rdata);
                chk("resp_other_rdata", other, 32'd0);
            end
        end
    end

    initial begin
        reset           = 1'b1;
        inst_sram_size  = SZ_WORD;
        data_sram_size  = SZ_WORD;
        inst_sram_wstrb = 4'hF;
        data_sram_wstrb = 4'hF;
        inst_sram_wdata = 32'd0;
        data_sram_wdata = 32'd0;
        inst_sram_addr  = 32'h1C00_0000;
        data_sram_addr  = 32'h1C00_0100;
        idle();
        // inputs active while in reset: every output must stay 0
        inst_sram_req = 1'b1;
        data_sram_req = 1'b1;
        mem_addr_ok   = 1'b1;
        mem_data_ok   = 1'b1;
        #3;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_addr_ok", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 32'd0);
        chk("rst_data_ok", 32'({inst_sram_data_ok, data_sram_data_ok}), 32'd0);
        tick();
        tick();
        idle();
        reset = 1'b0;
        tick();

        // both request together: data first, then inst; responses D then I
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1C00_0000;
        data_sram_req  = 1'b1;
        data_sram_addr = 32'h1C00_0100;
        mem_addr_ok    = 1'b1;
        @(negedge clk);
        chk("t1_mem_req", 32'(mem_req), 32'd1);
        chk("t1_mem_addr_data", mem_addr, 32'h1C00_0100);
        chk("t1_data_addr_ok", 32'(data_sram_addr_ok), 32'd1);
        chk("t1_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
        tick();
        data_sram_req = 1'b0;
        @(negedge clk);
        chk("t1_mem_addr_inst", mem_addr, 32'h1C00_0000);
        chk("t1_inst_addr_ok2", 32'(inst_sram_addr_ok), 32'd1);
        tick();
        idle();
        respond(SRC_DATA, 32'h1234_5678, 1'b1);
        tick();
        respond(SRC_INST, 32'hDEAD_BEEF, 1'b1);
        tick();
        idle();

        // inst stalled three cycles; a later data request must not pre-empt it
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1C00_0200;
        @(negedge clk);
        chk("t2_c1_mem_addr", mem_addr, 32'h1C00_0200);
        chk("t2_c1_mem_req", 32'(mem_req), 32'd1);
        tick();
        data_sram_req  = 1'b1;
        data_sram_addr = 32'h1C00_0300;
        @(negedge clk);
        chk("t2_c2_mem_addr", mem_addr, 32'h1C00_0200);
        tick();
        @(negedge clk);
        chk("t2_c3_mem_addr", mem_addr, 32'h1C00_0200);
        chk("t2_c3_data_addr_ok", 32'(data_sram_addr_ok), 32'd0);
        tick();
        mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("t2_accept_inst", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 32'b10);
        chk("t2_accept_addr", mem_addr, 32'h1C00_0200);
        tick();
        inst_sram_req = 1'b0;
        @(negedge clk);
        chk("t2_then_data_addr", mem_addr, 32'h1C00_0300);
        chk("t2_then_data_ok", 32'(data_sram_addr_ok), 32'd1);
        tick();
        idle();
        respond(SRC_INST, 32'h1111_1111, 1'b1);
        tick();
        respond(SRC_DATA, 32'h2222_2222, 1'b1);
        tick();
        idle();

        // full at OUTSTANDING=2, including a pop in the blocked cycle
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1C00_0500;
        mem_addr_ok    = 1'b1;
        @(negedge clk);
        chk("t3_acc1", 32'(inst_sram_addr_ok), 32'd1);
        tick();
        inst_sram_addr = 32'h1C00_0504;
        @(negedge clk);
        chk("t3_acc2", 32'(inst_sram_addr_ok), 32'd1);
        tick();
        inst_sram_addr = 32'h1C00_0508;
        @(negedge clk);
        chk("t3_full_mem_req", 32'(mem_req), 32'd0);
        chk("t3_full_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
        tick();
        respond(SRC_INST, 32'hA0A0_A0A0, 1'b1);
        @(negedge clk);
        chk("t3_full_pop_mem_req", 32'(mem_req), 32'd0);
        tick();
        mem_data_ok = 1'b0;
        @(negedge clk);
        chk("t3_after_pop_mem_req", 32'(mem_req), 32'd1);
        chk("t3_after_pop_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        chk("t3_after_pop_addr", mem_addr, 32'h1C00_0508);
        tick();
        idle();
        respond(SRC_INST, 32'hB0B0_B0B0, 1'b1);
        tick();
        respond(SRC_INST, 32'hC0C0_C0C0, 1'b1);
        tick();
        idle();

        // ten back-to-back transactions, push and pop together at count=1
        for (int k = 0; k <= 10; k++) begin
            idle();
            if (k < 10) begin
                mem_addr_ok = 1'b1;
                if (k % 2 == 1) begin
                    data_sram_req   = 1'b1;
                    data_sram_wr    = 1'b1;
                    data_sram_addr  = 32'h1C00_1000 + 32'(4 * k);
                    data_sram_wdata = 32'(k);
                end else begin
                    inst_sram_req  = 1'b1;
                    inst_sram_addr = 32'h1C00_1000 + 32'(4 * k);
                end
            end
            if (k > 0) begin
                respond(((k - 1) % 2 == 1) ? SRC_DATA : SRC_INST,
                        32'hC0DE_0000 + 32'(k - 1), ((k - 1) % 2 == 0));
            end
            @(negedge clk);
            if (k < 10) begin
                chk("t4_mem_req", 32'(mem_req), 32'd1);
                chk("t4_addr_ok", 32'({inst_sram_addr_ok, data_sram_addr_ok}),
                    (k % 2 == 1) ? 32'b01 : 32'b10);
                chk("t4_mem_addr", mem_addr, 32'h1C00_1000 + 32'(4 * k));
                chk("t4_mem_wr", 32'(mem_wr), 32'(k % 2));
                if (k % 2 == 1) chk("t4_mem_wdata", mem_wdata, 32'(k));
            end
            tick();
        end
        idle();
        tick();

        // spurious response with empty FIFO, then a real one
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("t5_spurious_data_ok", 32'({inst_sram_data_ok, data_sram_data_ok}), 32'd0);
        tick();
        idle();
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1C00_0600;
        mem_addr_ok    = 1'b1;
        @(negedge clk);
        chk("t5_accept", 32'(inst_sram_addr_ok), 32'd1);
        tick();
        idle();
        respond(SRC_INST, 32'h55AA_55AA, 1'b1);
        tick();
        idle();

        // asynchronous reset while locked with one transaction outstanding
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1C00_0700;
        mem_addr_ok    = 1'b1;
        tick();
        inst_sram_req  = 1'b0;
        data_sram_req  = 1'b1;
        data_sram_addr = 32'h1C00_0704;
        mem_addr_ok    = 1'b0;
        tick();
        #2;
        reset         = 1'b1;
        mem_data_ok   = 1'b1;
        mem_addr_ok   = 1'b1;
        inst_sram_req = 1'b1;
        #1;
        chk("t6_rst_mem_req", 32'(mem_req), 32'd0);
        chk("t6_rst_mem_addr", mem_addr, 32'd0);
        chk("t6_rst_addr_ok", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 32'd0);
        chk("t6_rst_data_ok", 32'({inst_sram_data_ok, data_sram_data_ok}), 32'd0);
        tick();
        idle();
        reset          = 1'b0;
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1C00_0800;
        mem_addr_ok    = 1'b1;
        @(negedge clk);
        chk("t6_post_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        chk("t6_post_mem_addr", mem_addr, 32'h1C00_0800);
        tick();
        inst_sram_req  = 1'b0;
        data_sram_req  = 1'b1;
        data_sram_addr = 32'h1C00_0804;
        @(negedge clk);
        chk("t6_post_data_addr_ok", 32'(data_sram_addr_ok), 32'd1);
        tick();
        idle();
        respond(SRC_INST, 32'h7777_7777, 1'b1);
        tick();
        respond(SRC_DATA, 32'h8888_8888, 1'b1);
        tick();
        idle();
        tick();
        tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
